mprj_io_cmd_rx: RTL and testbench
=================================

# mprj_io_cmd_rx

Pin-side command receiver in the user project area: samples the `sel`/`ad`/`dat` bus presented on `mprj_io` inputs by an external driver, filters it for stability and commits each new command into a 12-entry register bank (3 data banks × 4 addresses). Command `sel=2'b11` is a readback request, returned MSB-first on a serial output pin with a frame strobe. Sits between `user_project_wrapper` pad wiring and the user logic consuming the register bank.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required before a command is accepted (≥2).
- `DW`, 21: input data bus width (`mprj_io[20:0]`).
- `clock`  in  1  system clock.
- `resetb`  in  1  synchronous, active-low reset.
- `sel_i`  in  2  command select (`mprj_io[26:25]`): 00 bank A, 01 bank B, 10 bank C, 11 readback.
- `ad_i`  in  2  register address (`mprj_io[23:22]`).
- `dat_i`  in  DW  write data (`mprj_io[20:0]`); readback bank in `dat_i[1:0]`.
- `bank_a_o`  out  4×10  bank A registers, flattened, entry 0 in LSBs.
- `bank_b_o`  out  4×10  bank B registers.
- `bank_c_o`  out  4×20  bank C registers.
- `wr_stb_o`  out  1  one-cycle pulse on every committed write.
- `tx_o`  out  1  serial readback data (drives `mprj_io[27]`).
- `tx_frame_o`  out  1  high while `tx_o` carries valid readback bits (`mprj_io[28]`).
- `busy_o`  out  1  readback in progress.
- `io_oeb_o`  out  2  output enables for pins 28:27, active-low; constant 2'b00.

## Operation
- Inputs pass a 2-flop synchronizer (25 bits combined) before any use.
- Stability filter: counter reloads to 0 whenever the synchronized word `{sel,ad,dat}` differs from the previous cycle; saturates at `STABLE_CYCLES-1`. Word is "stable" when counter reaches `STABLE_CYCLES-1`.
- Accept rule: stable word that differs from `last_cmd` (last accepted word) is accepted once; `last_cmd` updated on accept. Re-presenting the same word does nothing.
- Write commands (sel 00/01/10): bank A/B store `dat[9:0]`, bank C stores `dat[19:0]` at address `ad`; upper bits discarded. `wr_stb_o` pulses the cycle the register updates.
- Readback (sel 11): bank = `dat[1:0]` (11 treated as bank C), address = `ad`. Selected value zero-extended to 20 bits, loaded into shift register.
- FSM: IDLE → (readback accepted) → SHIFT (20 cycles, MSB first, `tx_frame_o`=1) → GAP (1 cycle, frame low) → IDLE.
- Commands accepted during SHIFT/GAP: writes still commit immediately; a readback is held pending (one-deep) and starts after GAP; a second readback while pending overwrites the pending one.
- `last_cmd` resets to `{2'b00,2'b00,21'd0}`; therefore an all-zero word after reset is not a write until something else is presented first.

## Timing
- Reset values: all bank registers 0, `wr_stb_o`=0, `tx_o`=0, `tx_frame_o`=0, `busy_o`=0, FSM IDLE, pending cleared, filter counter 0.
- Write latency: input change at pins → `wr_stb_o` after 2 (sync) + `STABLE_CYCLES` + 1 cycles = 7 cycles for defaults; bank output visible same cycle as strobe.
- Readback: first bit on `tx_o` with `tx_frame_o`=1 the cycle after accept; `busy_o` high from that cycle through GAP.
- Write and readback of same register in one accepted command impossible (single command per accept); readback issued after a write sees the new value.
- Reset asserted mid-shift: frame drops next edge, no partial resume.

## Structure
- Package `mprj_io_cmd_pkg`: `sel` encodings (`SEL_A`, `SEL_B`, `SEL_C`, `SEL_RD`), bank widths (10/10/20), FSM state enum.
- Sub-module `mprj_io_stab_filter` (synchronizer + stability counter + accept pulse), parameterized on width and `STABLE_CYCLES`.

## Test plan
- Reset: hold `resetb`=0 10 cycles → all outputs 0, `io_oeb_o`=2'b00.
- Write A: sel=00, ad=1, dat=10'b1010101010 held 500 ns → `bank_a_o[19:10]`=0x2AA, exactly one `wr_stb_o`.
- Write C truncation: sel=10, ad=1, dat=21'h1FAAAA → entry1 of bank C = 20'hFAAAA; holding unchanged gives no further strobes.
- Glitch rejection: change dat for 2 cycles then revert → no write, no strobe.
- Readback: after write C, sel=11, ad=1, dat=2 → 20 frame cycles, bits 1111_1010_1010_1010_1010 MSB-first, then 1 gap cycle.
- Overlap: write B addr 3 = 0x155 while a readback shifts, then a second readback of B/3 → write commits mid-frame, second frame returns 0x00155 after GAP.

Source files
------------

// File: rtl/mprj_io_cmd_pkg.sv
// Shared encodings for the mprj_io command receiver: select codes,
// register bank widths and the readback serializer states.
package mprj_io_cmd_pkg;

  localparam logic [1:0] SEL_A  = 2'b00;
  localparam logic [1:0] SEL_B  = 2'b01;
  localparam logic [1:0] SEL_C  = 2'b10;
  localparam logic [1:0] SEL_RD = 2'b11;

  localparam int A_W = 10;
  localparam int B_W = 10;
  localparam int C_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } rx_state_e;

endpackage

// File: rtl/mprj_io_stab_filter.sv
// Two-flop synchronizer plus stability counter; flags a word once when it
// has been steady long enough and differs from the last accepted word.
module mprj_io_stab_filter #(
  parameter int W             = 25,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clock,
  input  logic         resetb,
  input  logic [W-1:0] din,
  output logic [W-1:0] word,
  output logic         accept
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [W-1:0]  sync_p0, sync_p1, prev_p2;
  logic [W-1:0]  last_cmd;
  logic [CW-1:0] cnt;

  // p0/p1: metastability stages, p2: previous-cycle copy for change detect
  always_ff @(posedge clock) begin
    sync_p0 <= din;
    sync_p1 <= sync_p0;
    prev_p2 <= sync_p1;
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      cnt      <= '0;
      last_cmd <= '0;
    end else begin
      if (sync_p1 != prev_p2)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      if (accept)
        last_cmd <= prev_p2;
    end
  end

  // The equality term blocks a stale saturated count from accepting a word
  // in the very cycle the input starts to change.
  assign word   = prev_p2;
  assign accept = (cnt == CNT_MAX) && (sync_p1 == prev_p2) && (prev_p2 != last_cmd);

endmodule

// File: rtl/mprj_io_cmd_rx.sv
// Pin-side command receiver: filtered commands write a 3x4 register bank
// or request a 20-bit MSB-first serial readback with a frame strobe.
module mprj_io_cmd_rx
  import mprj_io_cmd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DW            = 21
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic [1:0]    sel_i,
  input  logic [1:0]    ad_i,
  input  logic [DW-1:0] dat_i,
  output logic [39:0]   bank_a_o,
  output logic [39:0]   bank_b_o,
  output logic [79:0]   bank_c_o,
  output logic          wr_stb_o,
  output logic          tx_o,
  output logic          tx_frame_o,
  output logic          busy_o,
  output logic [1:0]    io_oeb_o
);

  localparam int CMD_W = DW + 4;

  logic [CMD_W-1:0] cmd;
  logic             accept;
  logic [1:0]       sel, ad, rd_bank;
  logic [C_W-1:0]   wdat;
  logic             unused_dat;
  logic             wr_acc, rd_acc;

  mprj_io_stab_filter #(
    .W             (CMD_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clock  (clock),
    .resetb (resetb),
    .din    ({sel_i, ad_i, dat_i}),
    .word   (cmd),
    .accept (accept)
  );

  assign sel        = cmd[DW+3:DW+2];
  assign ad         = cmd[DW+1:DW];
  assign wdat       = cmd[C_W-1:0];
  assign rd_bank    = cmd[1:0];
  assign unused_dat = ^cmd[DW-1:C_W];
  assign wr_acc     = accept && (sel != SEL_RD);
  assign rd_acc     = accept && (sel == SEL_RD);

  logic [A_W-1:0] bank_a [4];
  logic [B_W-1:0] bank_b [4];
  logic [C_W-1:0] bank_c [4];

  // Bank code 11 is read as bank C.
  function automatic logic [C_W-1:0] rd_value(input logic [1:0] bank, input logic [1:0] addr);
    case (bank)
      SEL_A:   return C_W'(bank_a[addr]);
      SEL_B:   return C_W'(bank_b[addr]);
      default: return bank_c[addr];
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!resetb) begin
      for (int i = 0; i < 4; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
        bank_c[i] <= '0;
      end
      wr_stb_o <= 1'b0;
    end else begin
      wr_stb_o <= wr_acc;
      if (wr_acc) begin
        case (sel)
          SEL_A:   bank_a[ad] <= wdat[A_W-1:0];
          SEL_B:   bank_b[ad] <= wdat[B_W-1:0];
          default: bank_c[ad] <= wdat;
        endcase
      end
    end
  end

  assign bank_a_o = {bank_a[3], bank_a[2], bank_a[1], bank_a[0]};
  assign bank_b_o = {bank_b[3], bank_b[2], bank_b[1], bank_b[0]};
  assign bank_c_o = {bank_c[3], bank_c[2], bank_c[1], bank_c[0]};
  assign io_oeb_o = 2'b00;

  rx_state_e      state;
  logic [4:0]     bit_cnt;
  logic [C_W-1:0] shreg;
  logic           pend;
  logic [1:0]     pend_bank, pend_ad;
  logic [C_W-1:0] start_val;

  // A readback arriving in GAP supersedes the pending one and starts directly.
  assign start_val = (state == ST_GAP && !rd_acc) ? rd_value(pend_bank, pend_ad)
                                                  : rd_value(rd_bank, ad);

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      pend       <= 1'b0;
      tx_o       <= 1'b0;
      tx_frame_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_acc) begin
            state      <= ST_SHIFT;
            tx_o       <= start_val[C_W-1];
            shreg      <= {start_val[C_W-2:0], 1'b0};
            bit_cnt    <= 5'(C_W - 1);
            tx_frame_o <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (rd_acc) begin
            pend      <= 1'b1;
            pend_bank <= rd_bank;
            pend_ad   <= ad;
          end
          if (bit_cnt == 5'd0) begin
            state      <= ST_GAP;
            tx_o       <= 1'b0;
            tx_frame_o <= 1'b0;
          end else begin
            tx_o    <= shreg[C_W-1];
            shreg   <= {shreg[C_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - 5'd1;
          end
        end
        ST_GAP: begin
          if (rd_acc || pend) begin
            pend       <= 1'b0;
            state      <= ST_SHIFT;
            tx_o       <= start_val[C_W-1];
            shreg      <= {start_val[C_W-2:0], 1'b0};
            bit_cnt    <= 5'(C_W - 1);
            tx_frame_o <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_io_cmd_rx.sv
// Directed bench for mprj_io_cmd_rx with a write/readback scoreboard.
module tb_mprj_io_cmd_rx;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic [1:0]  sel_i = '0;
  logic [1:0]  ad_i = '0;
  logic [20:0] dat_i = '0;
  logic [39:0] bank_a_o, bank_b_o;
  logic [79:0] bank_c_o;
  logic        wr_stb_o, tx_o, tx_frame_o, busy_o;
  logic [1:0]  io_oeb_o;

  mprj_io_cmd_rx #(.STABLE_CYCLES(4), .DW(21)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .sel_i      (sel_i),
    .ad_i       (ad_i),
    .dat_i      (dat_i),
    .bank_a_o   (bank_a_o),
    .bank_b_o   (bank_b_o),
    .bank_c_o   (bank_c_o),
    .wr_stb_o   (wr_stb_o),
    .tx_o       (tx_o),
    .tx_frame_o (tx_frame_o),
    .busy_o     (busy_o),
    .io_oeb_o   (io_oeb_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  ad;
    logic [19:0] val;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [19:0] rd_q[$];

  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total = 0;
  int          stb_seen = 0;
  int          rd_done = 0;
  int          rx_n = 0;
  logic [19:0] rx_sh = '0;
  bit          mon_en = 1'b0;
  bit          stb_in_frame = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] entry(input logic [1:0] s, input logic [1:0] a);
    case (s)
      2'b00:   return {10'd0, bank_a_o[int'(a)*10 +: 10]};
      2'b01:   return {10'd0, bank_b_o[int'(a)*10 +: 10]};
      default: return bank_c_o[int'(a)*20 +: 20];
    endcase
  endfunction

  task automatic step();
    wr_exp_t     e;
    logic [19:0] r;
    @(posedge clock);
    #1;
    if (mon_en) begin
      if (wr_stb_o) begin
        stb_seen++;
        stb_in_frame = tx_frame_o;
        if (wr_q.size() == 0) check("unexpected_wr_stb", 32'd1, 32'd0);
        else begin
          e = wr_q.pop_front();
          check($sformatf("wr_entry_s%0d_a%0d", e.sel, e.ad), entry(e.sel, e.ad), e.val);
        end
      end
      if (tx_frame_o) begin
        check("busy_in_frame", busy_o, 1'b1);
        rx_sh = {rx_sh[18:0], tx_o};
        rx_n++;
      end else if (rx_n != 0) begin
        check("frame_len", rx_n, 32'd20);
        check("busy_in_gap", busy_o, 1'b1);
        if (rd_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
        else begin
          r = rd_q.pop_front();
          check("rd_value", rx_sh, r);
        end
        rx_n = 0;
        rd_done++;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_stb(input string tag, input int budget, output int lat);
    int s0;
    s0  = stb_seen;
    lat = 0;
    while (stb_seen == s0 && lat < budget) begin
      step();
      lat++;
    end
    if (stb_seen == s0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rd(input string tag, input int budget);
    int s0, n;
    s0 = rd_done;
    n  = 0;
    while (rd_done == s0 && n < budget) begin
      step();
      n++;
    end
    if (rd_done == s0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_frame(input string tag, input int budget);
    int n;
    n = 0;
    while (!tx_frame_o && n < budget) begin
      step();
      n++;
    end
    if (!tx_frame_o) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drive(input logic [1:0] s, input logic [1:0] a, input logic [20:0] d);
    sel_i = s;
    ad_i  = a;
    dat_i = d;
  endtask

  initial begin
    int lat, s0;

    resetb = 1'b0;
    steps(10);
    check("rst_bank_a", bank_a_o, 32'd0);
    check("rst_bank_b", bank_b_o, 32'd0);
    check("rst_bank_c_lo", bank_c_o[39:0], 32'd0);
    check("rst_bank_c_hi", bank_c_o[79:40], 32'd0);
    check("rst_wr_stb", wr_stb_o, 1'b0);
    check("rst_tx", tx_o, 1'b0);
    check("rst_frame", tx_frame_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("io_oeb", io_oeb_o, 2'b00);

    resetb = 1'b1;
    mon_en = 1'b1;
    steps(20);
    check("zero_word_no_write", stb_seen, 32'd0);

    wr_q.push_back('{sel: 2'b00, ad: 2'd1, val: 20'h002AA});
    drive(2'b00, 2'd1, 21'h0002AA);
    wait_stb("wr_a", 20, lat);
    check("wr_latency", lat, 32'd7);
    steps(50 - lat);
    check("wr_a_strobes", stb_seen, 32'd1);
    check("bank_a_entry1", bank_a_o[19:10], 10'h2AA);
    check("bank_a_others", {bank_a_o[39:20], bank_a_o[9:0]}, 32'd0);

    wr_q.push_back('{sel: 2'b10, ad: 2'd1, val: 20'hFAAAA});
    drive(2'b10, 2'd1, 21'h1FAAAA);
    steps(40);
    check("wr_c_strobes", stb_seen, 32'd2);
    check("bank_c_entry1", bank_c_o[39:20], 20'hFAAAA);

    dat_i = 21'h1F5555;
    steps(2);
    dat_i = 21'h1FAAAA;
    steps(30);
    check("glitch_strobes", stb_seen, 32'd2);
    check("glitch_bank_c", bank_c_o[39:20], 20'hFAAAA);

    rd_q.push_back(20'hFAAAA);
    drive(2'b11, 2'd1, 21'd2);
    wait_rd("rd_c", 60);
    step();
    check("busy_after_gap", busy_o, 1'b0);
    check("frame_after_gap", tx_frame_o, 1'b0);

    rd_q.push_back(20'h002AA);
    drive(2'b11, 2'd1, 21'd0);
    wait_frame("ov_frame1", 30);
    wr_q.push_back('{sel: 2'b01, ad: 2'd3, val: 20'h00155});
    drive(2'b01, 2'd3, 21'h000155);
    wait_stb("wr_b", 20, lat);
    check("wr_b_mid_frame", stb_in_frame, 1'b1);
    rd_q.push_back(20'h00155);
    drive(2'b11, 2'd3, 21'd1);
    s0 = rd_done;
    wait_rd("ov_frame1_end", 40);
    step();
    check("back_to_back_frame", tx_frame_o, 1'b1);
    wait_rd("ov_frame2_end", 40);
    check("ov_frames", rd_done, s0 + 2);
    check("ov_queue_empty", rd_q.size(), 32'd0);

    drive(2'b11, 2'd1, 21'd2);
    wait_frame("rst_frame_start", 30);
    steps(5);
    mon_en = 1'b0;
    resetb = 1'b0;
    step();
    check("midrst_frame", tx_frame_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_tx", tx_o, 1'b0);
    check("midrst_bank_c", bank_c_o[39:20], 20'd0);
    check("midrst_wr_stb", wr_stb_o, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
